// File: rtl/switch_allocator.sv
// Switch allocator for a 5-port mesh router (N, S, E, W, L).
// Zero-latency, packet-locking, round-robin allocation of crossbar outputs.
// Port codes: N=0, S=1, E=2, W=3, L=4; an idle output select is 3'd7.

module switch_allocator_chk #(
  parameter int FLIT_W = 16
) (
  input logic        clk,
  input logic        rst,
  input logic [4:0]  req_i,
  input logic [4:0]  gnt_i,
  input logic [14:0] sel_i
);

  // Count outputs that are driving a real input this cycle.
  function automatic int busy_outputs(input logic [14:0] sel);
    int n;
    n = 0;
    for (int o = 0; o < 5; o++) begin
      if (sel[3*o +: 3] != 3'd7) begin
        n = n + 1;
      end else begin
      end
    end
    return n;
  endfunction

  a_flit_w: assert property (@(posedge clk) FLIT_W > 0);

  a_rst_idle: assert property (@(posedge clk)
    rst |-> ((gnt_i == 5'd0) && (sel_i == 15'h7FFF)));

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (rst)
    ((gnt_i & ~req_i) == 5'd0));

  a_one_to_one: assert property (@(posedge clk) disable iff (rst)
    ($countones(gnt_i) == busy_outputs(sel_i)));

  for (genvar o = 0; o < 5; o++) begin : g_out
    a_sel_valid: assert property (@(posedge clk) disable iff (rst)
      (sel_i[3*o +: 3] == 3'd7) ||
      ((sel_i[3*o +: 3] <= 3'd4) && gnt_i[sel_i[3*o +: 3]]));
  end

endmodule

module switch_allocator #(
  parameter int FLIT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_i,
  input  logic [14:0] dest_i,
  input  logic [4:0]  tail_i,
  output logic [4:0]  gnt_o,
  output logic [2:0]  N_port_select,
  output logic [2:0]  S_port_select,
  output logic [2:0]  E_port_select,
  output logic [2:0]  W_port_select,
  output logic [2:0]  L_port_select,
  output logic [4:0]  illegal_o
);

  localparam logic [2:0] SEL_IDLE = 3'd7;

  // Per-output state: lock flag, owning input and round-robin start point.
  logic [4:0] lock_q, lock_d;
  logic [2:0] owner_q [5];
  logic [2:0] owner_d [5];
  logic [2:0] rr_q    [5];
  logic [2:0] rr_d    [5];
  logic [4:0] illegal_q, illegal_d;

  // Decoded requests and per-output allocation result.
  logic [2:0] dst_s   [5];
  logic [4:0] legal_s;
  logic [2:0] win_s   [5];
  logic [4:0] win_v_s;
  logic [4:0] gnt_s;

  // (a + b) mod 5 for port indices; both operands are already below 5.
  function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 4'd5) begin
      return 3'(sum - 4'd5);
    end else begin
      return sum[2:0];
    end
  endfunction

  // Split the packed destination bus into one code per input.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      dst_s[i] = dest_i[3*i +: 3];
    end
  end

  // A request is legal when it names a real port other than its own input.
  always_comb begin
    legal_s = 5'd0;
    for (int i = 0; i < 5; i++) begin
      legal_s[i] = req_i[i] && (dst_s[i] <= 3'd4) && (dst_s[i] != 3'(i));
    end
  end

  // Pick one winner per output: the owner if locked, otherwise round-robin.
  always_comb begin
    logic       found_v;
    logic [2:0] cand_v;
    found_v = 1'b0;
    cand_v  = 3'd0;
    win_v_s = 5'd0;
    for (int o = 0; o < 5; o++) begin
      win_s[o] = SEL_IDLE;
      found_v  = 1'b0;
      if (rst) begin
      end else if (lock_q[o]) begin
        // A locked output waits for its owner; anyone else sees a bubble.
        if (legal_s[owner_q[o]] && (dst_s[owner_q[o]] == 3'(o))) begin
          win_v_s[o] = 1'b1;
          win_s[o]   = owner_q[o];
        end else begin
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          cand_v = add_mod5(rr_q[o], 3'(k));
          if (!found_v && legal_s[cand_v] && (dst_s[cand_v] == 3'(o))) begin
            found_v    = 1'b1;
            win_v_s[o] = 1'b1;
            win_s[o]   = cand_v;
          end else begin
          end
        end
      end
    end
  end

  // Fold the per-output winners into the per-input grant vector.
  always_comb begin
    gnt_s = 5'd0;
    for (int o = 0; o < 5; o++) begin
      if (win_v_s[o]) begin
        gnt_s[win_s[o]] = 1'b1;
      end else begin
      end
    end
  end

  // Next-state for locks and pointers driven by this cycle's grants.
  always_comb begin
    lock_d    = lock_q;
    illegal_d = req_i & ~legal_s;
    for (int o = 0; o < 5; o++) begin
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      if (win_v_s[o]) begin
        if (tail_i[win_s[o]]) begin
          // Packet ends: release and move priority just past the winner.
          lock_d[o] = 1'b0;
          rr_d[o]   = add_mod5(win_s[o], 3'd1);
        end else if (!lock_q[o]) begin
          // Head of a multi-flit packet claims the output.
          lock_d[o]  = 1'b1;
          owner_d[o] = win_s[o];
        end else begin
        end
      end else begin
      end
    end
  end

  // Register allocation state and the one-cycle illegal-request pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 5'd0;
      illegal_q <= 5'd0;
      for (int o = 0; o < 5; o++) begin
        owner_q[o] <= 3'd0;
        rr_q[o]    <= 3'd0;
      end
    end else begin
      lock_q    <= lock_d;
      illegal_q <= illegal_d;
      for (int o = 0; o < 5; o++) begin
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  assign gnt_o         = gnt_s;
  assign N_port_select = win_s[0];
  assign S_port_select = win_s[1];
  assign E_port_select = win_s[2];
  assign W_port_select = win_s[3];
  assign L_port_select = win_s[4];
  assign illegal_o     = illegal_q;

  switch_allocator_chk #(.FLIT_W(FLIT_W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i),
    .gnt_i (gnt_s),
    .sel_i ({win_s[4], win_s[3], win_s[2], win_s[1], win_s[0]})
  );

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: directed scenarios plus random
// packet traffic, checked against a behavioural allocation model.

module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_i;
  logic [14:0] dest_i;
  logic [4:0]  tail_i;
  logic [4:0]  gnt_o;
  logic [2:0]  N_port_select, S_port_select, E_port_select, W_port_select, L_port_select;
  logic [4:0]  illegal_o;

  always #5 clk = ~clk;

  switch_allocator #(.FLIT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .dest_i        (dest_i),
    .tail_i        (tail_i),
    .gnt_o         (gnt_o),
    .N_port_select (N_port_select),
    .S_port_select (S_port_select),
    .E_port_select (E_port_select),
    .W_port_select (W_port_select),
    .L_port_select (L_port_select),
    .illegal_o     (illegal_o)
  );

  typedef struct packed {
    logic [4:0]  gnt;
    logic [14:0] sel;
    logic [4:0]  ill;
  } exp_t;

  exp_t expq [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: owner per output (-1 = free) and next-priority input.
  int         m_own [5];
  int         m_rr  [5];
  logic [4:0] m_ill;
  logic [4:0] last_g;

  bit          ov_en  = 1'b0;
  logic [4:0]  ov_g;
  logic [14:0] ov_s;
  bit          ovi_en = 1'b0;
  logic [4:0]  ovi;

  localparam logic [14:0] IDLE = 15'h7FFF;

  function automatic logic [14:0] pk(input int n, input int s, input int e, input int w, input int l);
    return {3'(l), 3'(w), 3'(e), 3'(s), 3'(n)};
  endfunction

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
  endtask

  // Allocation rules applied directly: owner wins a held output, else first
  // legal requester scanning from the priority pointer.
  task automatic model(input logic r, input logic [4:0] rq, input logic [14:0] ds,
                       input logic [4:0] tl, output logic [4:0] g,
                       output logic [14:0] sel, output logic [4:0] ill_now);
    int d [5];
    bit ok [5];
    int w;
    int c;
    logic [4:0] nxt_ill;
    g = 5'd0;
    sel = IDLE;
    nxt_ill = 5'd0;
    for (int i = 0; i < 5; i++) begin
      d[i] = int'(ds[3*i +: 3]);
      ok[i] = rq[i] && (d[i] <= 4) && (d[i] != i);
      if (rq[i] && !ok[i]) nxt_ill[i] = 1'b1;
    end
    if (r) begin
      for (int o = 0; o < 5; o++) begin
        m_own[o] = -1;
        m_rr[o] = 0;
      end
      nxt_ill = 5'd0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        w = -1;
        if (m_own[o] >= 0) begin
          if (ok[m_own[o]] && d[m_own[o]] == o) w = m_own[o];
        end else begin
          for (int k = 0; k < 5; k++) begin
            c = (m_rr[o] + k) % 5;
            if (w < 0 && ok[c] && d[c] == o) w = c;
          end
        end
        if (w >= 0) begin
          g[w] = 1'b1;
          sel[3*o +: 3] = 3'(w);
          if (tl[w]) begin
            m_own[o] = -1;
            m_rr[o] = (w + 1) % 5;
          end else if (m_own[o] < 0) begin
            m_own[o] = w;
          end
        end
      end
    end
    ill_now = m_ill;
    m_ill = nxt_ill;
  endtask

  // Apply one cycle of inputs and queue what the outputs must show.
  task automatic step(input logic r, input logic [4:0] rq, input logic [14:0] ds, input logic [4:0] tl);
    exp_t e;
    logic [4:0] g;
    logic [14:0] s;
    logic [4:0] il;
    rst = r;
    req_i = rq;
    dest_i = ds;
    tail_i = tl;
    model(r, rq, ds, tl, g, s, il);
    e.gnt = g;
    e.sel = s;
    e.ill = il;
    if (ov_en) begin
      e.gnt = ov_g;
      e.sel = ov_s;
      ov_en = 1'b0;
    end
    if (ovi_en) begin
      e.ill = ovi;
      ovi_en = 1'b0;
    end
    expq.push_back(e);
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  // Directed step with hand-derived grant/select expectations.
  task automatic dstep(input logic r, input logic [4:0] rq, input logic [14:0] ds,
                       input logic [4:0] tl, input logic [4:0] g, input logic [14:0] s);
    ov_en = 1'b1;
    ov_g = g;
    ov_s = s;
    step(r, rq, ds, tl);
  endtask

  // Monitor: compare every cycle's outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("gnt", {10'd0, gnt_o}, {10'd0, e.gnt});
        chk("sel", {L_port_select, W_port_select, E_port_select, S_port_select, N_port_select}, e.sel);
        chk("illegal", {10'd0, illegal_o}, {10'd0, e.ill});
      end
    end
  end

  int left [5];
  int gap  [5];
  int pdst [5];

  initial begin
    for (int o = 0; o < 5; o++) begin
      m_own[o] = -1;
      m_rr[o] = 0;
      left[o] = 0;
      gap[o] = 0;
      pdst[o] = (o + 1) % 5;
    end
    m_ill = 5'd0;
    last_g = 5'd0;
    rst = 1'b1;
    req_i = 5'd0;
    dest_i = 15'd0;
    tail_i = 5'd0;
    @(posedge clk);
    #1;

    // Reset state.
    dstep(1'b1, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);
    dstep(1'b1, 5'b11111, pk(1, 0, 3, 2, 2), 5'd0, 5'd0, IDLE);

    // N and S both want E with single flits: N first, then S.
    dstep(1'b0, 5'b00011, pk(2, 2, 0, 0, 0), 5'b00011, 5'b00001, pk(7, 7, 0, 7, 7));
    dstep(1'b0, 5'b00011, pk(2, 2, 0, 0, 0), 5'b00011, 5'b00010, pk(7, 7, 1, 7, 7));
    dstep(1'b0, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);

    // W holds L for 3 flits with a 2-cycle bubble; then N wins via wrap.
    dstep(1'b1, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);
    dstep(1'b0, 5'b01000, pk(4, 4, 4, 4, 0), 5'b00000, 5'b01000, pk(7, 7, 7, 7, 3));
    dstep(1'b0, 5'b01111, pk(4, 4, 4, 4, 0), 5'b00111, 5'b01000, pk(7, 7, 7, 7, 3));
    dstep(1'b0, 5'b00111, pk(4, 4, 4, 4, 0), 5'b00111, 5'b00000, IDLE);
    dstep(1'b0, 5'b00111, pk(4, 4, 4, 4, 0), 5'b00111, 5'b00000, IDLE);
    dstep(1'b0, 5'b01111, pk(4, 4, 4, 4, 0), 5'b01111, 5'b01000, pk(7, 7, 7, 7, 3));
    dstep(1'b0, 5'b00111, pk(4, 4, 4, 4, 0), 5'b00111, 5'b00001, pk(7, 7, 7, 7, 0));
    dstep(1'b0, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);

    // Illegal destinations: E to itself, L to code 5.
    dstep(1'b0, 5'b10100, pk(0, 0, 2, 0, 5), 5'b10100, 5'd0, IDLE);
    ovi_en = 1'b1;
    ovi = 5'b10100;
    dstep(1'b0, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);

    // Disjoint traffic; L queues behind W for E.
    dstep(1'b1, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);
    dstep(1'b0, 5'b11111, pk(1, 0, 3, 2, 2), 5'b11111, 5'b01111, pk(1, 0, 3, 2, 7));
    dstep(1'b0, 5'b10000, pk(1, 0, 3, 2, 2), 5'b11111, 5'b10000, pk(7, 7, 4, 7, 7));
    dstep(1'b0, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);

    // Reset drops S's lock on E mid-packet; N then wins E.
    dstep(1'b1, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);
    dstep(1'b0, 5'b00010, pk(2, 2, 0, 0, 0), 5'b00000, 5'b00010, pk(7, 7, 1, 7, 7));
    dstep(1'b0, 5'b00011, pk(2, 2, 0, 0, 0), 5'b00001, 5'b00010, pk(7, 7, 1, 7, 7));
    dstep(1'b1, 5'b00011, pk(2, 2, 0, 0, 0), 5'b00001, 5'b00000, IDLE);
    dstep(1'b0, 5'b00011, pk(2, 2, 0, 0, 0), 5'b00001, 5'b00001, pk(7, 7, 0, 7, 7));
    dstep(1'b0, 5'b00010, pk(2, 2, 0, 0, 0), 5'b00000, 5'b00010, pk(7, 7, 1, 7, 7));
    dstep(1'b0, 5'b00010, pk(2, 2, 0, 0, 0), 5'b00010, 5'b00010, pk(7, 7, 1, 7, 7));
    dstep(1'b0, 5'd0, 15'd0, 5'd0, 5'd0, IDLE);

    // Random packet traffic with pauses, illegal one-shots and rare resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [4:0] rq;
      logic [4:0] tl;
      logic [14:0] ds;
      logic r;
      rq = 5'd0;
      tl = 5'd0;
      ds = 15'd0;
      for (int i = 0; i < 5; i++) begin
        int dsel;
        bit ill1;
        int pick;
        ill1 = 1'b0;
        dsel = pdst[i];
        if (gap[i] > 0) begin
          gap[i]--;
        end else if (left[i] == 0) begin
          pick = $urandom_range(0, 9);
          if (pick == 0) begin
            ill1 = 1'b1;
            pick = $urandom_range(0, 3);
            dsel = (pick == 0) ? i : 4 + pick;
          end else if (pick < 7) begin
            left[i] = $urandom_range(1, 4);
            pdst[i] = (i + $urandom_range(1, 4)) % 5;
            dsel = pdst[i];
          end
        end
        rq[i] = ill1 || (left[i] > 0 && gap[i] == 0);
        tl[i] = (left[i] == 1);
        ds[3*i +: 3] = 3'(dsel);
      end
      r = ($urandom_range(0, 199) == 0);
      step(r, rq, ds, tl);
      for (int i = 0; i < 5; i++) begin
        if (last_g[i]) begin
          left[i]--;
          gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
      end
    end

    step(1'b0, 5'd0, 15'd0, 5'd0);
    for (int t = 0; t < 8 && expq.size() != 0; t++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
